pcileech_com_tx_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter sharing the single 32-bit FT601 TX path between the

---
 rtl/pcileech_com_tx_arbiter_pkg.sv | 30 +++
 rtl/pcileech_skid_buf.sv | 76 +++++++
 rtl/pcileech_com_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_pcileech_com_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_com_tx_arbiter_pkg.sv
// rtl/pcileech_com_tx_arbiter_pkg.sv - shared types and constants for the COM TX arbiter
//
// Purpose: FSM encodings, upstream source ids and the skid-buffer word width
//          used by pcileech_com_tx_arbiter and pcileech_skid_buf.
// Ports:   none (package).

package pcileech_com_tx_arbiter_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ABORT = 2'd2} tx_arb_state_t;

  // Legacy-style state constants; the FSM register is plain logic [1:0].
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  // Upstream source ids carried on m_tsrc.
  localparam logic [1:0] SRC_TLP = 2'd0;
  localparam logic [1:0] SRC_CFG = 2'd1;
  localparam logic [1:0] SRC_CMD = 2'd2;

  // Skid word layout: {data[31:0], src[1:0], last}.
  localparam int SKID_WIDTH = 35;

  // Round-robin successor of source g among num sources.
  function automatic logic [1:0] next_src(input logic [1:0] g, input int num);
    if (int'(g) >= num - 1) return 2'd0;
    return g + 2'd1;
  endfunction

endpackage

// File: rtl/pcileech_skid_buf.sv
// rtl/pcileech_skid_buf.sv - two-entry skid buffer with registered outputs and ready
//
// Purpose: decouples the arbiter from COM TX back-pressure. Sustains one word per
//          cycle while keeping out_* and in_ready as flop outputs.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/valid/ready   upstream word, in_ready is registered
//   out_data/valid/ready  downstream word, out_* held stable while stalled
//   busy                  any entry occupied

module pcileech_skid_buf
  import pcileech_com_tx_arbiter_pkg::*;
#(
  parameter int WIDTH = SKID_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  logic [WIDTH-1:0] spare_data, spare_data_n, out_data_n;
  logic             spare_valid, spare_valid_n, out_valid_n;
  logic             push, pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign busy = out_valid | spare_valid;

  // The head entry drives the outputs; the spare entry absorbs the one word that
  // can arrive in the cycle the downstream stalls, since in_ready lags by a cycle.
  always_comb begin
    out_data_n    = out_data;
    out_valid_n   = out_valid;
    spare_data_n  = spare_data;
    spare_valid_n = spare_valid;
    if (spare_valid) begin
      if (pop) begin
        out_data_n    = spare_data;
        spare_valid_n = 1'b0;
      end
    end else if (push) begin
      if (!out_valid || pop) begin
        out_data_n  = in_data;
        out_valid_n = 1'b1;
      end else begin
        spare_data_n  = in_data;
        spare_valid_n = 1'b1;
      end
    end else if (pop) begin
      out_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      spare_data  <= '0;
      spare_valid <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      out_data    <= out_data_n;
      out_valid   <= out_valid_n;
      spare_data  <= spare_data_n;
      spare_valid <= spare_valid_n;
      in_ready    <= !spare_valid_n;
    end
  end

endmodule

// File: rtl/pcileech_com_tx_arbiter.sv
// rtl/pcileech_com_tx_arbiter.sv - packet-atomic round-robin arbiter for the FT601 TX path
//
// Purpose: shares the single 32-bit COM TX stream between TLP, CFG and command
//          sources. Holds the grant until tlast, aborts source stalls by timeout
//          and tags every output word with its source id.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   en                              allow new grants (current packet always completes)
//   s_tdata/tvalid/tlast/tready     per-source streams, source i at [32*i+:32] / [i]
//   m_tdata/tsrc/tvalid/tlast/tready  merged stream to COM TX
//   busy                            FSM not idle or skid buffer occupied
//   err_abort                       one-cycle pulse per aborted packet
//   cnt_pkt                         completed packets including aborts, wrapping

module pcileech_com_tx_arbiter
  import pcileech_com_tx_arbiter_pkg::*;
#(
  parameter int          PARAM_NUM_SRC    = 3,
  parameter int          PARAM_TIMEOUT    = 1024,
  parameter logic [31:0] PARAM_ABORT_WORD = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [32*PARAM_NUM_SRC-1:0] s_tdata,
  input  logic [PARAM_NUM_SRC-1:0]   s_tvalid,
  input  logic [PARAM_NUM_SRC-1:0]   s_tlast,
  output logic [PARAM_NUM_SRC-1:0]   s_tready,
  output logic [31:0]                m_tdata,
  output logic [1:0]                 m_tsrc,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic                       busy,
  output logic                       err_abort,
  output logic [15:0]                cnt_pkt
);

  localparam int TMO_W = $clog2(PARAM_TIMEOUT);

  logic [1:0]            state, grant, rr_ptr, pick;
  logic                  pick_found;
  logic [2:0]            idx;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [31:0]           g_data;
  logic                  g_valid, g_last, g_accept;
  logic                  skid_in_valid, skid_in_ready, skid_busy;
  logic [SKID_WIDTH-1:0] skid_in_data, skid_out_data;

  // First requester at or after rr_ptr. Scanning from the far end down lets the
  // nearest match overwrite the others.
  always_comb begin
    pick       = 2'd0;
    pick_found = 1'b0;
    idx        = 3'd0;
    for (int k = PARAM_NUM_SRC - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + 3'(k);
      if (idx >= 3'(PARAM_NUM_SRC)) idx = idx - 3'(PARAM_NUM_SRC);
      if (s_tvalid[idx[1:0]]) begin
        pick       = idx[1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Granted source's stream.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < PARAM_NUM_SRC; i++) begin
      if (grant == 2'(i)) begin
        g_data  = s_tdata[32*i +: 32];
        g_valid = s_tvalid[i];
        g_last  = s_tlast[i];
      end
    end
  end

  always_comb begin
    s_tready = '0;
    if (state == ST_GRANT) begin
      for (int i = 0; i < PARAM_NUM_SRC; i++) begin
        if (grant == 2'(i)) s_tready[i] = skid_in_ready;
      end
    end
  end

  assign g_accept      = (state == ST_GRANT) && g_valid && skid_in_ready;
  assign skid_in_valid = (state == ST_GRANT) ? g_valid : (state == ST_ABORT);
  assign skid_in_data  = (state == ST_ABORT) ? {PARAM_ABORT_WORD, grant, 1'b1}
                                             : {g_data, grant, g_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= 2'd0;
      rr_ptr    <= 2'd0;
      tmo_cnt   <= '0;
      cnt_pkt   <= 16'd0;
      err_abort <= 1'b0;
    end else begin
      err_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && pick_found) begin
            grant   <= pick;
            tmo_cnt <= '0;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A word held back only by COM TX back-pressure still counts as activity,
          // so downstream stalls never age the timeout; a last word always wins.
          if (g_valid) begin
            tmo_cnt <= '0;
            if (g_accept && g_last) begin
              rr_ptr  <= next_src(grant, PARAM_NUM_SRC);
              cnt_pkt <= cnt_pkt + 16'd1;
              state   <= ST_IDLE;
            end
          end else if (tmo_cnt == TMO_W'(PARAM_TIMEOUT - 1)) begin
            tmo_cnt <= '0;
            state   <= ST_ABORT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_ABORT: begin
          if (skid_in_ready) begin
            err_abort <= 1'b1;
            rr_ptr    <= next_src(grant, PARAM_NUM_SRC);
            cnt_pkt   <= cnt_pkt + 16'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pcileech_skid_buf #(
    .WIDTH(SKID_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (skid_in_data),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .out_data (skid_out_data),
    .out_valid(m_tvalid),
    .out_ready(m_tready),
    .busy     (skid_busy)
  );

  assign m_tdata = skid_out_data[34:3];
  assign m_tsrc  = skid_out_data[2:1];
  assign m_tlast = skid_out_data[0];
  assign busy    = (state != ST_IDLE) || skid_busy;

endmodule

// File: tb/tb_pcileech_com_tx_arbiter.sv
// tb/tb_pcileech_com_tx_arbiter.sv - scoreboard bench for pcileech_com_tx_arbiter

module tb_pcileech_com_tx_arbiter;

  localparam int NUM = 3;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [95:0]   s_tdata;
  logic [2:0]    s_tvalid, s_tlast, s_tready;
  logic [31:0]   m_tdata;
  logic [1:0]    m_tsrc;
  logic          m_tvalid, m_tlast, m_tready, busy, err_abort;
  logic [15:0]   cnt_pkt;

  always #5 clk = ~clk;

  pcileech_com_tx_arbiter #(
    .PARAM_NUM_SRC(NUM),
    .PARAM_TIMEOUT(TMO),
    .PARAM_ABORT_WORD(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tsrc(m_tsrc), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .busy(busy), .err_abort(err_abort), .cnt_pkt(cnt_pkt)
  );

  typedef struct packed { logic [31:0] d; logic l; logic [7:0] gap; } beat_t;
  typedef struct packed { logic [31:0] d; logic l; } exp_t;

  beat_t srcq [NUM][$];
  exp_t  expq [NUM][$];
  int    exp_order[$];
  int    tests = 0;
  int    fails = 0;
  int    abort_seen = 0;
  logic  rand_ready = 1'b0;
  logic  hold_low = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic add_pkt(input int s, input logic [31:0] base, input int len, input int gap);
    for (int w = 0; w < len; w++) begin
      beat_t b;
      b.d = base + 32'(w);
      b.l = (w == len - 1);
      b.gap = 8'(gap);
      srcq[s].push_back(b);
      expq[s].push_back({b.d, b.l});
    end
  endtask

  function automatic bit all_empty();
    for (int s = 0; s < NUM; s++)
      if (srcq[s].size() != 0 || expq[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < NUM; s++) begin
      srcq[s].delete();
      expq[s].delete();
    end
    exp_order.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busy && all_empty();
    end
    chk({"drain_", name}, 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_tready(input int s, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = s_tready[s];
    end
    chk($sformatf("grant_seen_src%0d", s), 64'(ok), 64'd1);
  endtask

  // Source driver: presents each queued beat after its gap, holds it until accepted.
  initial begin
    logic [2:0] hs;
    int gapc [NUM];
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b1; hs = '0;
    for (int s = 0; s < NUM; s++) gapc[s] = 0;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk); #1;
      if (!rst_n) begin
        s_tvalid = '0; s_tdata = '0; s_tlast = '0;
        for (int s = 0; s < NUM; s++) gapc[s] = 0;
      end else begin
        m_tready = hold_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        for (int s = 0; s < NUM; s++) begin
          if (hs[s] && srcq[s].size() > 0) begin
            void'(srcq[s].pop_front());
            gapc[s] = 0;
          end
          if (srcq[s].size() > 0 && gapc[s] >= int'(srcq[s][0].gap)) begin
            s_tvalid[s] = 1'b1;
            s_tdata[32*s +: 32] = srcq[s][0].d;
            s_tlast[s] = srcq[s][0].l;
          end else begin
            s_tvalid[s] = 1'b0;
            s_tdata[32*s +: 32] = '0;
            s_tlast[s] = 1'b0;
            if (srcq[s].size() > 0) gapc[s]++;
          end
        end
      end
    end
  end

  // Monitor: per-source scoreboard, packet atomicity, grant order, stall stability.
  initial begin
    logic       pkt_open, prev_stall;
    logic [1:0] cur_src;
    logic [34:0] prev_word;
    exp_t       e;
    int         s;
    pkt_open = 1'b0; prev_stall = 1'b0; cur_src = 2'd0; prev_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pkt_open = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (err_abort) abort_seen++;
        if (prev_stall) begin
          chk("hold_valid", 64'(m_tvalid), 64'd1);
          chk("hold_word", 64'({m_tdata, m_tsrc, m_tlast}), 64'(prev_word));
        end
        if (m_tvalid && m_tready) begin
          s = int'(m_tsrc);
          if (s >= NUM || expq[s].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got src %0d data 0x%0h, expected no word", s, m_tdata);
          end else begin
            e = expq[s].pop_front();
            chk($sformatf("word_src%0d", s), 64'({m_tdata, m_tlast}), 64'(e));
          end
          if (!pkt_open) begin
            if (exp_order.size() > 0) chk("grant_order", 64'(s), 64'(exp_order.pop_front()));
            cur_src = m_tsrc;
          end else begin
            chk("packet_atomic", 64'(m_tsrc), 64'(cur_src));
          end
          pkt_open = !m_tlast;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_word = {m_tdata, m_tsrc, m_tlast};
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any;
    int n, a0;
    bit seen;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    en = 1'b1;

    // 1: idle after reset
    any = 1'b0;
    repeat (100) begin
      @(negedge clk);
      any |= m_tvalid | busy | err_abort | (|s_tready);
    end
    chk("idle_activity", 64'(any), 64'd0);
    chk("idle_cnt_pkt", 64'(cnt_pkt), 64'd0);

    // 2: single 4-word packet from src0, latency 2
    @(negedge clk);
    exp_order.push_back(0);
    add_pkt(0, 32'h1, 4, 0);
    @(negedge clk);
    chk("lat_c0_s_tready", 64'(s_tready), 64'd0);
    @(negedge clk);
    chk("lat_c1_s_tready", 64'(s_tready), 64'b001);
    chk("lat_c1_m_tvalid", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_c2_m_tvalid", 64'(m_tvalid), 64'd1);
    chk("lat_c2_m_tdata", 64'(m_tdata), 64'h1);
    wait_drain("t2", 200);
    chk("t2_cnt_pkt", 64'(cnt_pkt), 64'd1);

    // 3: all sources with two 2-word packets, rr from 0
    do_reset();
    @(negedge clk);
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NUM; s++) begin
        add_pkt(s, 32'h3000_0000 + 32'(s * 256 + p * 16), 2, 0);
        exp_order.push_back(s);
      end
    wait_drain("t3", 300);
    chk("t3_cnt_pkt", 64'(cnt_pkt), 64'd6);

    // 4: src1 stalls after one word -> abort, then src2 before src0
    do_reset();
    @(negedge clk);
    exp_order.push_back(0);
    add_pkt(0, 32'h40, 1, 0);
    wait_drain("t4a", 100);
    a0 = abort_seen;
    exp_order.push_back(1); exp_order.push_back(2);
    exp_order.push_back(0); exp_order.push_back(1);
    srcq[1].push_back('{d: 32'h41, l: 1'b0, gap: 8'd0});
    expq[1].push_back('{d: 32'h41, l: 1'b0});
    expq[1].push_back('{d: 32'hDEADBEEF, l: 1'b1});
    srcq[1].push_back('{d: 32'h51, l: 1'b1, gap: 8'd40});
    expq[1].push_back('{d: 32'h51, l: 1'b1});
    wait_tready(1, 20);
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 4) begin
        add_pkt(2, 32'h42, 1, 0);
        add_pkt(0, 32'h43, 1, 0);
      end
      seen = err_abort;
    end
    chk("abort_latency", 64'(n), 64'd18);
    chk("abort_m_tdata", 64'(m_tdata), 64'hDEADBEEF);
    chk("abort_m_tsrc", 64'(m_tsrc), 64'd1);
    chk("abort_m_tlast", 64'(m_tlast), 64'd1);
    wait_drain("t4", 300);
    chk("t4_abort_pulses", 64'(abort_seen - a0), 64'd1);
    chk("t4_cnt_pkt", 64'(cnt_pkt), 64'd5);

    // 5a: long m_tready stall mid-packet never times out
    do_reset();
    a0 = abort_seen;
    @(negedge clk);
    add_pkt(0, 32'h500, 6, 0);
    wait_tready(0, 20);
    hold_low = 1'b1;
    repeat (40) @(negedge clk);
    hold_low = 1'b0;
    wait_drain("t5a", 200);
    chk("t5a_no_abort", 64'(abort_seen - a0), 64'd0);

    // 5b: 1000 random packets, random m_tready
    do_reset();
    rand_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      int s;
      s = $urandom_range(0, NUM - 1);
      add_pkt(s, (32'(i) << 8) | (32'(s) << 4), $urandom_range(1, 4), $urandom_range(0, 3));
    end
    wait_drain("t5b", 40000);
    rand_ready = 1'b0;
    chk("t5b_cnt_pkt", 64'(cnt_pkt), 64'd1000);
    chk("t5b_no_abort", 64'(abort_seen - a0), 64'd0);

    // 6: en drop mid-packet, then reset mid-packet
    do_reset();
    @(negedge clk);
    exp_order.push_back(0);
    add_pkt(0, 32'h60, 4, 2);
    wait_tready(0, 20);
    en = 1'b0;
    exp_order.push_back(1);
    add_pkt(1, 32'h70, 4, 2);
    n = 0;
    while (n < 200 && !(expq[0].size() == 0 && !busy)) begin
      @(negedge clk);
      n++;
    end
    chk("t6_src0_complete", 64'(expq[0].size()), 64'd0);
    repeat (20) @(negedge clk);
    chk("t6_en0_s_tready", 64'(s_tready), 64'd0);
    chk("t6_en0_busy", 64'(busy), 64'd0);
    chk("t6_en0_pending", 64'(srcq[1].size()), 64'd4);
    chk("t6_en0_cnt_pkt", 64'(cnt_pkt), 64'd1);
    en = 1'b1;
    wait_tready(1, 20);
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_m_tsrc", 64'(m_tsrc), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_abort", 64'(err_abort), 64'd0);
    chk("rst_cnt_pkt", 64'(cnt_pkt), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(2);
    add_pkt(2, 32'h82, 1, 0);
    add_pkt(1, 32'h81, 1, 0);
    add_pkt(0, 32'h80, 1, 0);
    wait_drain("t6", 200);
    chk("t6_cnt_pkt", 64'(cnt_pkt), 64'd3);
    chk("order_consumed", 64'(exp_order.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
